// File: rtl/scale_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// scale_sweep_ctrl
//   Steps the clock divider's scale input through a programmed frequency sweep
//   (start, start+step, ... stop). Each value is held for a programmed number of
//   rising edges of the divided clock that the divider feeds back. Mode 0 runs a
//   single up-sweep and pulses done_o. Mode 1 ping-pongs between start and stop
//   until it is aborted.
//
// Ports
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   start_i      start request (level), acted on only while idle
//   abort_i      abort request, highest priority after reset
//   cfg_start_i  first scale value
//   cfg_stop_i   end scale value
//   cfg_step_i   scale increment
//   cfg_dwell_i  divided-clock edges per value (0 behaves as 1)
//   cfg_mode_i   0 = single up-sweep, 1 = ping-pong
//   div_clk_i    divided clock from the divider (synchronous to clk_i)
//   scale_o      scale value to the divider
//   scale_vld_o  one-cycle pulse in the cycle scale_o takes a new value
//   busy_o       sweep in progress
//   done_o       one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module scale_sweep_ctrl #(
  parameter int FSC_WD = 16,
  parameter int DWL_WD = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [FSC_WD-1:0] cfg_start_i,
  input  logic [FSC_WD-1:0] cfg_stop_i,
  input  logic [FSC_WD-1:0] cfg_step_i,
  input  logic [DWL_WD-1:0] cfg_dwell_i,
  input  logic              cfg_mode_i,
  input  logic              div_clk_i,
  output logic [FSC_WD-1:0] scale_o,
  output logic              scale_vld_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [FSC_WD-1:0] scale_q, scale_d;
  logic              vld_q, vld_d;
  logic              dir_dn_q, dir_dn_d;
  logic [DWL_WD-1:0] cnt_q, cnt_d;
  logic              div_q;

  // Configuration captured at start so later cfg_* changes cannot disturb a sweep.
  logic [FSC_WD-1:0] start_s_q, start_s_d;
  logic [FSC_WD-1:0] stop_s_q, stop_s_d;
  logic [FSC_WD-1:0] step_s_q, step_s_d;
  logic [DWL_WD-1:0] dwell_s_q, dwell_s_d;
  logic              mode_s_q, mode_s_d;

  logic              div_edge;
  logic [DWL_WD-1:0] dwell_last;
  logic              degenerate;
  logic [FSC_WD:0]   up_sum;
  logic [FSC_WD-1:0] up_next;
  logic [FSC_WD-1:0] dn_gap;
  logic [FSC_WD-1:0] dn_next;

  assign div_edge   = div_clk_i & ~div_q;
  assign dwell_last = (dwell_s_q == '0) ? '0 : dwell_s_q - DWL_WD'(1);
  assign degenerate = (step_s_q == '0) || (start_s_q >= stop_s_q);

  // One extra bit on the sum so a step past the top of the range clamps to
  // stop instead of wrapping to a small value.
  assign up_sum  = {1'b0, scale_q} + {1'b0, step_s_q};
  assign up_next = (up_sum > {1'b0, stop_s_q}) ? stop_s_q : up_sum[FSC_WD-1:0];

  // Going down scale_q never sits below start, so the gap cannot underflow;
  // comparing against it avoids underflowing scale_q - step.
  assign dn_gap  = scale_q - start_s_q;
  assign dn_next = (step_s_q > dn_gap) ? start_s_q : scale_q - step_s_q;

  always_comb begin
    state_d   = state_q;
    scale_d   = scale_q;
    vld_d     = 1'b0;
    dir_dn_d  = dir_dn_q;
    cnt_d     = cnt_q;
    start_s_d = start_s_q;
    stop_s_d  = stop_s_q;
    step_s_d  = step_s_q;
    dwell_s_d = dwell_s_q;
    mode_s_d  = mode_s_q;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            start_s_d = cfg_start_i;
            stop_s_d  = cfg_stop_i;
            step_s_d  = cfg_step_i;
            dwell_s_d = cfg_dwell_i;
            mode_s_d  = cfg_mode_i;
            dir_dn_d  = 1'b0;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          scale_d = start_s_q;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (div_edge) begin
            if (cnt_q == dwell_last) begin
              cnt_d   = '0;
              state_d = S_STEP;
            end else begin
              cnt_d = cnt_q + DWL_WD'(1);
            end
          end
        end
        S_STEP: begin
          if (degenerate) begin
            state_d = S_DONE;
          end else if (!dir_dn_q) begin
            if (scale_q < stop_s_q) begin
              scale_d = up_next;
              vld_d   = 1'b1;
              state_d = S_DWELL;
            end else if (!mode_s_q) begin
              state_d = S_DONE;
            end else begin
              // Turn around at stop; start < stop so the down step is valid.
              dir_dn_d = 1'b1;
              scale_d  = dn_next;
              vld_d    = 1'b1;
              state_d  = S_DWELL;
            end
          end else begin
            if (scale_q > start_s_q) begin
              scale_d = dn_next;
            end else begin
              dir_dn_d = 1'b0;
              scale_d  = up_next;
            end
            vld_d   = 1'b1;
            state_d = S_DWELL;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      scale_q   <= '0;
      vld_q     <= 1'b0;
      dir_dn_q  <= 1'b0;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      start_s_q <= '0;
      stop_s_q  <= '0;
      step_s_q  <= '0;
      dwell_s_q <= '0;
      mode_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      scale_q   <= scale_d;
      vld_q     <= vld_d;
      dir_dn_q  <= dir_dn_d;
      cnt_q     <= cnt_d;
      div_q     <= div_clk_i;
      start_s_q <= start_s_d;
      stop_s_q  <= stop_s_d;
      step_s_q  <= step_s_d;
      dwell_s_q <= dwell_s_d;
      mode_s_q  <= mode_s_d;
    end
  end

  assign scale_o     = scale_q;
  assign scale_vld_o = vld_q;
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_DWELL) || (state_q == S_STEP);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_scale_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scale_sweep_ctrl
//   Scoreboard bench. Each sweep request pushes the expected value sequence
//   (derived from the start/stop/step/dwell rules) into exp_q; a monitor pops
//   an entry on every scale_vld_o / done_o pulse and also checks that each value
//   was held for the expected number of divided-clock rising edges.
// -----------------------------------------------------------------------------
module tb_scale_sweep_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        start_i, abort_i;
  logic [15:0] cfg_start_i, cfg_stop_i, cfg_step_i, cfg_dwell_i;
  logic        cfg_mode_i;
  logic        div_clk_i;
  logic [15:0] scale_o;
  logic        scale_vld_o, busy_o, done_o;

  // Narrow instance for the no-wrap check at the top of an 8-bit range.
  logic        start8_i;
  logic [7:0]  cfg8_start, cfg8_stop, cfg8_step;
  logic [15:0] cfg8_dwell;
  logic [7:0]  scale8_o;
  logic        scale8_vld_o, busy8_o, done8_o;

  scale_sweep_ctrl #(.FSC_WD(16), .DWL_WD(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_step_i(cfg_step_i),
    .cfg_dwell_i(cfg_dwell_i), .cfg_mode_i(cfg_mode_i), .div_clk_i(div_clk_i),
    .scale_o(scale_o), .scale_vld_o(scale_vld_o), .busy_o(busy_o), .done_o(done_o)
  );

  scale_sweep_ctrl #(.FSC_WD(8), .DWL_WD(16)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start8_i), .abort_i(abort_i),
    .cfg_start_i(cfg8_start), .cfg_stop_i(cfg8_stop), .cfg_step_i(cfg8_step),
    .cfg_dwell_i(cfg8_dwell), .cfg_mode_i(1'b0), .div_clk_i(div_clk_i),
    .scale_o(scale8_o), .scale_vld_o(scale8_vld_o), .busy_o(busy8_o), .done_o(done8_o)
  );

  typedef struct {
    bit is_done;
    int val;
    int dwell;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops = 0;
  int   last_val = 0;
  int   cur_dwell = 0;
  int   cnt = 0;
  bit   armed = 0;
  bit   have_prev = 0;
  bit   div_prev = 0;
  bit   div_manual = 0;
  int   lo_left = 0;
  int   obs8[$];
  int   done8_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Divided clock: one cycle high, then 1..3 cycles low.
  always begin
    @(posedge clk);
    #1;
    if (!div_manual) begin
      if (div_clk_i) begin
        div_clk_i = 1'b0;
        lo_left   = $urandom_range(0, 2);
      end else if (lo_left == 0) begin
        div_clk_i = 1'b1;
      end else begin
        lo_left--;
      end
    end
  end

  // Monitor: negedge sees outputs after the last edge and the div_clk level the
  // DUT samples at the next edge.
  always @(negedge clk) begin
    bit   edge_now;
    exp_t it;
    edge_now = div_clk_i && !div_prev;
    div_prev = div_clk_i;
    if (scale_vld_o === 1'b1 || done_o === 1'b1) begin
      if (have_prev) chk("dwell_edges", cnt, cur_dwell);
      chk("event_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        chk("event_kind", done_o, it.is_done);
        if (scale_vld_o === 1'b1) begin
          chk("scale", scale_o, it.val[15:0]);
          chk("busy_on_vld", busy_o, 1);
          last_val  = it.val;
          cur_dwell = it.dwell;
          cnt       = 0;
          armed     = 1;
          have_prev = 1;
          pops++;
        end else begin
          chk("busy_on_done", busy_o, 0);
          armed     = 0;
          have_prev = 0;
        end
        $display("[TB] event kind=%0d scale=%0d exp_val=%0d", done_o, scale_o, it.val);
      end else begin
        armed     = 0;
        have_prev = 0;
      end
    end
    if (armed && edge_now) begin
      cnt++;
      if (cnt == cur_dwell) armed = 0;
    end
  end

  always @(negedge clk) begin
    if (scale8_vld_o === 1'b1) obs8.push_back(int'(scale8_o));
    if (done8_o === 1'b1) done8_cnt++;
  end

  task automatic push_val(input int v, input int dwe);
    exp_t e;
    e.is_done = 0;
    e.val     = v;
    e.dwell   = dwe;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1;
    e.val     = -1;
    e.dwell   = 0;
    exp_q.push_back(e);
  endtask

  // Reference: up list U = start..stop clamped at stop, down list D = stop..start
  // clamped at start. Mode 1 plays U, D[1:], U[1:], ... forever.
  task automatic push_model(input int s, input int e, input int st, input int dw,
                            input bit md, output bit finite);
    int dwe;
    int u[$];
    int d[$];
    int v;
    int total;
    dwe = (dw == 0) ? 1 : dw;
    if (st == 0 || s >= e) begin
      push_val(s, dwe);
      push_done();
      finite = 1;
      return;
    end
    v = s;
    u.push_back(v);
    while (v < e) begin
      v = (v + st > e) ? e : v + st;
      u.push_back(v);
    end
    if (!md) begin
      foreach (u[i]) push_val(u[i], dwe);
      push_done();
      finite = 1;
      return;
    end
    v = e;
    d.push_back(v);
    while (v > s) begin
      v = (v - st < s) ? s : v - st;
      d.push_back(v);
    end
    foreach (u[i]) push_val(u[i], dwe);
    total = u.size();
    while (total < 60) begin
      for (int i = 1; i < d.size(); i++) push_val(d[i], dwe);
      for (int i = 1; i < u.size(); i++) push_val(u[i], dwe);
      total += d.size() + u.size() - 2;
    end
    finite = 0;
  endtask

  task automatic flush();
    exp_q.delete();
    armed     = 0;
    have_prev = 0;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((busy_o !== 1'b0 || exp_q.size() != 0) && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk({name, "_all_events_seen"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy_o, 0);
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      flush();
    end
  endtask

  task automatic run_sweep(input int s, input int e, input int st, input int dw,
                           input bit md, input bit disturb, input int n_abort,
                           input string name);
    bit finite;
    int cyc;
    $display("[TB] %s: start=%0d stop=%0d step=%0d dwell=%0d mode=%0d", name, s, e, st, dw, md);
    cfg_start_i = 16'(s);
    cfg_stop_i  = 16'(e);
    cfg_step_i  = 16'(st);
    cfg_dwell_i = 16'(dw);
    cfg_mode_i  = md;
    pops = 0;
    push_model(s, e, st, dw, md, finite);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({name, "_busy_latency"}, busy_o, 1);
    chk({name, "_no_vld_in_load"}, scale_vld_o, 0);
    tick();
    chk({name, "_first_vld"}, scale_vld_o, 1);
    chk({name, "_first_scale"}, scale_o, 16'(s));
    if (disturb) begin
      repeat ($urandom_range(2, 10)) tick();
      if (busy_o === 1'b1) begin
        cfg_start_i = 16'($urandom_range(0, 500));
        cfg_stop_i  = 16'($urandom_range(0, 500));
        cfg_step_i  = 16'($urandom_range(0, 50));
        cfg_dwell_i = 16'($urandom_range(0, 4));
        cfg_mode_i  = ~md;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
      end
    end
    if (finite) begin
      wait_idle(name);
    end else begin
      cyc = 0;
      while (pops < n_abort && cyc < 20000) begin
        tick();
        cyc++;
      end
      chk({name, "_pops_reached"}, pops >= n_abort, 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk({name, "_abort_busy"}, busy_o, 0);
      chk({name, "_abort_vld"}, scale_vld_o, 0);
      chk({name, "_abort_done"}, done_o, 0);
      chk({name, "_abort_hold"}, scale_o, 16'(last_val));
      tick();
      chk({name, "_abort_still_idle"}, busy_o, 0);
      flush();
      repeat (4) tick();
    end
  endtask

  initial begin
    bit finite;
    int cyc;
    rst_ni = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    start8_i = 1'b0;
    div_clk_i = 1'b0;
    cfg_start_i = '0; cfg_stop_i = '0; cfg_step_i = '0; cfg_dwell_i = '0; cfg_mode_i = 1'b0;
    cfg8_start = 8'd250; cfg8_stop = 8'd255; cfg8_step = 8'd10; cfg8_dwell = 16'd1;
    tick();
    chk("reset_scale", scale_o, 0);
    chk("reset_vld", scale_vld_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    run_sweep(10, 40, 10, 2, 0, 0, 0, "up_basic");
    run_sweep(10, 35, 10, 1, 0, 0, 0, "up_clamp");

    // 8-bit instance: 250 + 10 must clamp to 255, not wrap.
    obs8.delete();
    done8_cnt = 0;
    tick();
    start8_i = 1'b1;
    tick();
    start8_i = 1'b0;
    cyc = 0;
    while (done8_cnt == 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("w8_done", done8_cnt, 1);
    chk("w8_count", obs8.size(), 2);
    if (obs8.size() >= 2) begin
      chk("w8_first", obs8[0], 250);
      chk("w8_second", obs8[1], 255);
    end
    $display("[TB] w8: values=%0d done=%0d", obs8.size(), done8_cnt);

    run_sweep(0, 20, 10, 1, 1, 0, 9, "pingpong");
    run_sweep(50, 20, 5, 3, 0, 0, 0, "degen_order");
    run_sweep(50, 80, 0, 3, 0, 0, 0, "degen_step0");
    run_sweep(50, 80, 0, 2, 1, 0, 0, "degen_mode1");
    run_sweep(10, 40, 10, 0, 0, 0, 0, "dwell0");

    // start and abort together in idle: nothing happens.
    cfg_start_i = 16'd7; cfg_stop_i = 16'd30; cfg_step_i = 16'd3; cfg_dwell_i = 16'd1;
    tick();
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start_abort_busy", busy_o, 0);
    repeat (3) tick();
    chk("start_abort_busy_later", busy_o, 0);
    chk("start_abort_scale_held", scale_o, 16'(last_val));
    $display("[TB] start+abort in idle: busy=%0d", busy_o);

    run_sweep(5, 200, 15, 2, 0, 1, 0, "mid_start_and_cfg");

    // Edge sampled in the LOAD cycle must not count toward the first dwell.
    div_manual = 1;
    div_clk_i = 1'b0;
    cfg_start_i = 16'd10; cfg_stop_i = 16'd20; cfg_step_i = 16'd10;
    cfg_dwell_i = 16'd1; cfg_mode_i = 1'b0;
    push_model(10, 20, 10, 1, 0, finite);
    tick();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    div_clk_i = 1'b1;
    tick();
    div_clk_i = 1'b0;
    tick();
    tick();
    div_clk_i = 1'b1;
    tick();
    div_clk_i = 1'b0;
    repeat (3) tick();
    div_clk_i = 1'b1;
    tick();
    div_clk_i = 1'b0;
    div_manual = 0;
    wait_idle("load_edge");

    // Reset in the middle of a sweep.
    cfg_start_i = 16'd0; cfg_stop_i = 16'd100; cfg_step_i = 16'd10;
    cfg_dwell_i = 16'd3; cfg_mode_i = 1'b0;
    pops = 0;
    push_model(0, 100, 10, 3, 0, finite);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (pops < 3 && cyc < 2000) begin
      tick();
      cyc++;
    end
    tick();
    rst_ni = 1'b0;
    tick();
    chk("midrst_scale", scale_o, 0);
    chk("midrst_vld", scale_vld_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    rst_ni = 1'b1;
    flush();
    $display("[TB] mid-sweep reset: scale=%0d busy=%0d", scale_o, busy_o);
    tick();
    run_sweep(0, 100, 10, 3, 0, 0, 0, "after_reset");

    for (int r = 0; r < 12; r++) begin
      run_sweep($urandom_range(0, 200), $urandom_range(0, 300), $urandom_range(0, 40),
                $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)), 0, "rnd_up");
    end
    for (int r = 0; r < 3; r++) begin
      int s;
      s = $urandom_range(0, 100);
      run_sweep(s, s + $urandom_range(1, 100), $urandom_range(1, 30),
                $urandom_range(0, 2), 1, 0, $urandom_range(5, 15), "rnd_pp");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scale_sweep_ctrl.md
Name: scale_sweep_ctrl

Overview:
- Sequencer for the signal-generator clock divider. It drives the divider's scale input through a programmed frequency sweep: start, start+step, ... up to stop.
- Each scale value is held for a programmed number of divided-clock periods, counted on rising edges of the divided clock fed back from the divider.
- Supports single-shot up-sweep and continuous ping-pong sweep. Sits between the test-control registers/buttons and the divider.

Parameters:
- FSC_WD, 16, width of scale values (matches divider scale width)
- DWL_WD, 16, width of dwell count

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
- start_i  in  1  start request, level-sampled, acted on only in IDLE
- abort_i  in  1  abort request, highest priority
- cfg_start_i  in  FSC_WD  first scale value
- cfg_stop_i  in  FSC_WD  end scale value
- cfg_step_i  in  FSC_WD  scale increment
- cfg_dwell_i  in  DWL_WD  divided-clock periods per value; 0 treated as 1
- cfg_mode_i  in  1  0 = single up-sweep, 1 = ping-pong until abort
- div_clk_i  in  1  divided clock from the divider (synchronous to clk_i)
- scale_o  out  FSC_WD  scale value to the divider
- scale_vld_o  out  1  one-cycle pulse in the cycle scale_o takes a new value
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse on normal sweep completion

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state IDLE; scale_o=0, scale_vld_o=0, busy_o=0, done_o=0; direction=up; dwell counter=0; div_clk edge register=0.
- Edge detect: div_q <= div_clk_i every cycle. An edge is div_clk_i=1 and div_q=0. Edges are counted only in DWELL; edges in LOAD or STEP cycles are dropped.
- Abort: abort_i=1 in any state returns the block to IDLE at the next edge.
  - busy_o=0 and done_o=0; scale_o holds its value; no scale_vld_o pulse.
  - abort_i wins over start_i and over any dwell or step event in the same cycle.
- IDLE: busy_o=0. If start_i=1 (and abort_i=0), shadow all cfg_* into internal registers, set direction=up, go to LOAD. cfg_* changes outside this cycle have no effect.
- LOAD (1 cycle): busy_o=1; scale_o <= start value, scale_vld_o=1, dwell counter <= 0; go to DWELL.
- Latency: start_i sampled at edge N gives busy_o=1 after N and scale_o/scale_vld_o updated after N+1.
- DWELL: on each counted edge:
  - If dwell counter = dwell-1 (dwell 0 treated as 1): counter <= 0, go to STEP.
  - Otherwise: counter + 1.
- STEP (1 cycle): compute the next value per the rules below. On a new value, update scale_o with a scale_vld_o pulse and go to DWELL. If the sweep is finished, go to DONE.
  - Degenerate config (step = 0, or start >= stop): sweep is finished after the first dwell, in both modes.
  - Up, scale_o < stop: next = min(scale_o + step, stop). Sum is computed in FSC_WD+1 bits, so there is no wrap and stop is always played.
  - Up, scale_o = stop, mode 0: finished.
  - Up, scale_o = stop, mode 1: direction <= down; apply the down rule.
  - Down, scale_o > start: next = max(scale_o - step, start). Computed without underflow; if step > scale_o - start, next = start.
  - Down, scale_o = start: direction <= up; apply the up rule.
- DONE (1 cycle): done_o=1, busy_o=0, scale_o holds the final value; go to IDLE.
- start_i while busy_o=1 is ignored.
- Reset mid-sweep behaves exactly as reset from idle. Reset takes priority over abort_i and start_i.

Test Plan:
- FSC_WD=16, start=10, stop=40, step=10, dwell=2, mode 0 -> scale_o 10,20,30,40 with one scale_vld_o pulse each; each held for 2 div_clk rising edges; done_o one pulse after the 2nd edge on 40; busy_o low the same cycle.
- start=10, stop=35, step=10, dwell=1 -> 10,20,30,35, then done_o. Then FSC_WD=8, start=250, stop=255, step=10 -> 250,255 with no wrap to a small value.
- mode 1, start=0, stop=20, step=10, dwell=1 -> 0,10,20,10,0,10,20...; done_o never asserts. abort_i -> busy_o=0 next cycle, scale_o holds, no done_o.
- Degenerate: start=50, stop=20, step=5, dwell=3 -> 50 held for 3 edges, then done_o. step=0 gives the same single-value result. dwell=0 behaves as dwell=1.
- Priority and shadowing:
  - start_i and abort_i both high in IDLE -> stays IDLE.
  - start_i pulsed mid-sweep -> ignored.
  - cfg_* changed mid-sweep -> sequence unchanged.
  - div_clk edge during the LOAD or STEP cycle -> not counted.
- rst_ni=0 for one cycle mid-DWELL -> all outputs return to reset values at that edge. The next start_i restarts from the start value.
